// File: rtl/mux_piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_piso_serializer_pkg
// Description : Shared state encoding and sizing helper for the mux-based
//               parallel-in/serial-out serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_piso_serializer_pkg;

    // Two-state controller: waiting for a word, or emitting its bits
    typedef logic [0:0] state_t;

    localparam state_t c_IDLE  = 1'b0;
    localparam state_t c_SHIFT = 1'b1;

    // Counter must hold the value WIDTH itself (bits remaining after a load)
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_piso_serializer_mux2x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_piso_serializer_mux2x1
// Description : Single-bit 2:1 multiplexer cell; selects i_d1 when i_sel=1.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_piso_serializer_mux2x1 (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule
`default_nettype wire

// File: rtl/mux_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mux_piso_serializer
// Description : Parallel-in/serial-out shift register with valid/ready on the
//               load and serial sides. Each storage bit is steered by a 2:1
//               mux (load vs shift neighbour). Supports zero-bubble
//               back-to-back words by accepting a new word together with the
//               last bit of the current one.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_piso_serializer
    import mux_piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done
);

    localparam int                 c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_sout_hs;
    logic               w_last;
    logic               w_load;
    logic               w_en;
    logic [WIDTH-1:0]   w_next;

    // Handshake and status decode
    assign sout_valid = (r_state == c_SHIFT);
    assign w_sout_hs  = sout_valid & sout_ready;
    assign w_last     = (r_state == c_SHIFT) & (r_cnt == c_CNT_ONE);
    assign load_ready = (r_state == c_IDLE) | (w_last & sout_ready);
    assign w_load     = load_valid & load_ready;
    assign done       = w_sout_hs & w_last;
    assign w_en       = w_load | w_sout_hs;

    // Per-bit next value: din bit on load, otherwise the shift neighbour
    // (zero fill at the end that empties out of the register)
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_nb;

        if (MSB_FIRST != 0) begin : g_msb
            if (i == 0) begin : g_fill
                assign w_nb = 1'b0;
            end else begin : g_inner
                assign w_nb = r_sreg[i-1];
            end
        end else begin : g_lsb
            if (i == WIDTH - 1) begin : g_fill
                assign w_nb = 1'b0;
            end else begin : g_inner
                assign w_nb = r_sreg[i+1];
            end
        end

        mux_piso_serializer_mux2x1 u_mux (
            .i_d0  (w_nb),
            .i_d1  (din[i]),
            .i_sel (w_load),
            .o_y   (w_next[i])
        );
    end

    // Serial bit taken from the end of the register that leaves first
    if (MSB_FIRST != 0) begin : g_out_msb
        assign sout = r_sreg[WIDTH-1];
    end else begin : g_out_lsb
        assign sout = r_sreg[0];
    end

    // Register stage: update only on a load or a serial handshake, so a
    // stalled consumer leaves the word untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (w_en) begin
            r_sreg <= w_next;
        end
    end

    // Controller and bits-remaining counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_load) begin
                        r_state <= c_SHIFT;
                        r_cnt   <= c_CNT_FULL;
                    end
                end
                c_SHIFT: begin
                    if (w_sout_hs) begin
                        if (w_last) begin
                            if (w_load) begin
                                r_cnt <= c_CNT_FULL;
                            end else begin
                                r_state <= c_IDLE;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
